// File: rtl/linebuf_scanout.sv
// linebuf_scanout: double-buffered scanline buffer feeding the VGA pixel path.
// The sprite drawers fill the draw buffer. At the same time the display buffer
// streams out, and each entry is cleared after it is read. The two buffers swap
// on every line_start, and the next sprite draw pass is launched one cycle later.
//
// Ports:
//   clk, reset            single clock, synchronous active-high reset
//   pixel_col/data, wren  sprite writes into the draw buffer
//   line_start, next_line scanline boundary pulse and line number to draw next
//   disp_valid, disp_col  display read request (result two cycles later)
//   bg_color              RGB888 shown for empty/transparent or out-of-range entries
//   ready                 high once the power-up clear of both buffers is done
//   draw_start, draw_line one-cycle draw launch and its line number
//   rgb, rgb_valid        expanded RGB888 pixel; rgb holds while rgb_valid is low
module linebuf_scanout #(
  parameter int unsigned WIDTH = 640,
  parameter logic [15:0] EMPTY = 16'h8000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  pixel_col,
  input  logic [15:0] pixel_data,
  input  logic        wren,
  input  logic        line_start,
  input  logic [9:0]  next_line,
  input  logic        disp_valid,
  input  logic [9:0]  disp_col,
  input  logic [23:0] bg_color,
  output logic        ready,
  output logic        draw_start,
  output logic [9:0]  draw_line,
  output logic [23:0] rgb,
  output logic        rgb_valid
);

  localparam int unsigned AW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [10:0] WidthCols = 11'(WIDTH);
  localparam logic [AW-1:0] LastAddr = AW'(WIDTH - 1);

  typedef enum logic {StInitClear, StRun} state_e;

  state_e          state_q;
  logic [AW-1:0]   clr_addr_q;
  logic            disp_sel_q;

  // Read stage: address and buffer select are captured together, so a swap
  // landing during an in-flight read cannot redirect it or its clear.
  logic            rd_valid_q;
  logic            rd_hit_q;
  logic            rd_sel_q;
  logic [AW-1:0]   rd_addr_q;
  logic [15:0]     rd_data_q;

  logic [15:0]     buf0 [WIDTH];
  logic [15:0]     buf1 [WIDTH];

  logic            running;
  logic            wr_hit;
  logic            disp_hit;
  logic            init_we;
  logic            draw_we;
  logic            clr_we;
  logic            rd_en;
  logic            bypass;
  logic [23:0]     rgb_d;

  always_comb begin
    running  = (state_q == StRun) && !reset;
    wr_hit   = {1'b0, pixel_col} < WidthCols;
    disp_hit = {1'b0, disp_col} < WidthCols;
    init_we  = (state_q == StInitClear) && !reset;
    draw_we  = running && wren && wr_hit;
    clr_we   = rd_valid_q && rd_hit_q && !reset;
    rd_en    = running && disp_valid && disp_hit;
    // A re-read of the entry being cleared this cycle must already see EMPTY.
    bypass   = clr_we && (rd_sel_q == disp_sel_q) && (rd_addr_q == disp_col[AW-1:0]);
  end

  // Buffer storage. The draw write comes after the clear, so if a post-swap
  // clear and a new-line draw hit the same entry, the new draw data survives.
  always_ff @(posedge clk) begin
    if (init_we) begin
      buf0[clr_addr_q] <= EMPTY;
      buf1[clr_addr_q] <= EMPTY;
    end
    if (clr_we) begin
      if (rd_sel_q) buf1[rd_addr_q] <= EMPTY;
      else          buf0[rd_addr_q] <= EMPTY;
    end
    if (draw_we) begin
      if (!disp_sel_q) buf1[pixel_col[AW-1:0]] <= pixel_data;
      else             buf0[pixel_col[AW-1:0]] <= pixel_data;
    end
    if (rd_en) begin
      if (bypass)          rd_data_q <= EMPTY;
      else if (disp_sel_q) rd_data_q <= buf1[disp_col[AW-1:0]];
      else                 rd_data_q <= buf0[disp_col[AW-1:0]];
    end
  end

  // RGB555 -> RGB888 by replicating the top bits into the low bits.
  always_comb begin
    rgb_d = bg_color;
    if (rd_hit_q && !rd_data_q[15]) begin
      rgb_d = {rd_data_q[14:10], rd_data_q[14:12],
               rd_data_q[9:5],   rd_data_q[9:7],
               rd_data_q[4:0],   rd_data_q[4:2]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StInitClear;
      clr_addr_q <= '0;
      ready      <= 1'b0;
      disp_sel_q <= 1'b0;
      draw_start <= 1'b0;
      draw_line  <= '0;
      rd_valid_q <= 1'b0;
      rd_hit_q   <= 1'b0;
      rd_sel_q   <= 1'b0;
      rd_addr_q  <= '0;
      rgb        <= '0;
      rgb_valid  <= 1'b0;
    end else begin
      draw_start <= 1'b0;
      rd_valid_q <= 1'b0;
      rgb_valid  <= rd_valid_q;
      if (rd_valid_q) rgb <= rgb_d;
      unique case (state_q)
        StInitClear: begin
          clr_addr_q <= clr_addr_q + 1'b1;
          if (clr_addr_q == LastAddr) begin
            clr_addr_q <= '0;
            state_q    <= StRun;
            ready      <= 1'b1;
          end
        end
        StRun: begin
          if (line_start) begin
            disp_sel_q <= ~disp_sel_q;
            draw_start <= 1'b1;
            draw_line  <= next_line;
          end
          rd_valid_q <= disp_valid;
          rd_hit_q   <= disp_hit;
          rd_sel_q   <= disp_sel_q;
          rd_addr_q  <= disp_col[AW-1:0];
        end
        default: state_q <= StInitClear;
      endcase
    end
  end

endmodule

// File: tb/tb_linebuf_scanout.sv
// Self-checking bench for linebuf_scanout: directed scenarios plus random
// traffic, compared every cycle against a behavioural two-buffer model.
module tb_linebuf_scanout;

  localparam int W = 640;
  localparam logic [15:0] EMPTY = 16'h8000;

  logic        clk;
  logic        reset;
  logic [9:0]  pixel_col;
  logic [15:0] pixel_data;
  logic        wren;
  logic        line_start;
  logic [9:0]  next_line;
  logic        disp_valid;
  logic [9:0]  disp_col;
  logic [23:0] bg_color;
  logic        ready;
  logic        draw_start;
  logic [9:0]  draw_line;
  logic [23:0] rgb;
  logic        rgb_valid;

  linebuf_scanout #(.WIDTH(W), .EMPTY(EMPTY)) dut (
    .clk        (clk),
    .reset      (reset),
    .pixel_col  (pixel_col),
    .pixel_data (pixel_data),
    .wren       (wren),
    .line_start (line_start),
    .next_line  (next_line),
    .disp_valid (disp_valid),
    .disp_col   (disp_col),
    .bg_color   (bg_color),
    .ready      (ready),
    .draw_start (draw_start),
    .draw_line  (draw_line),
    .rgb        (rgb),
    .rgb_valid  (rgb_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Behavioural model: two line arrays, a display select, and the cycle count
  // since reset (inputs only take effect once the init clear has finished).
  logic [15:0] mbuf [2][W];
  int          msel;
  int          mcyc;
  logic        p_v;
  logic [23:0] p_rgb;
  logic [23:0] last_rgb;
  logic [9:0]  m_line;

  function automatic logic [23:0] expand(input logic [15:0] v, input logic [23:0] bg);
    if (v[15]) return bg;
    return {v[14:10], v[14:12], v[9:5], v[9:7], v[4:0], v[4:2]};
  endfunction

  // One clock cycle: apply this cycle's inputs to the model, clock the DUT,
  // then compare every output.
  task automatic tick();
    logic        nv;
    logic [23:0] nrgb;
    logic        ls;
    nv   = 1'b0;
    nrgb = '0;
    ls   = 1'b0;
    if (mcyc >= W) begin
      if (disp_valid) begin
        nv = 1'b1;
        if (int'(disp_col) < W) begin
          nrgb = expand(mbuf[msel][disp_col], bg_color);
          mbuf[msel][disp_col] = EMPTY;
        end else begin
          nrgb = bg_color;
        end
      end
      if (wren && int'(pixel_col) < W) mbuf[1 - msel][pixel_col] = pixel_data;
      if (line_start) begin
        msel   = 1 - msel;
        m_line = next_line;
        ls     = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    mcyc++;
    check("ready", 32'(ready), 32'(mcyc >= W));
    check("draw_start", 32'(draw_start), 32'(ls));
    check("draw_line", 32'(draw_line), 32'(m_line));
    check("rgb_valid", 32'(rgb_valid), 32'(p_v));
    if (p_v) last_rgb = p_rgb;
    check("rgb", 32'(rgb), 32'(last_rgb));
    p_v   = nv;
    p_rgb = nrgb;
  endtask

  task automatic idle_inputs();
    wren       = 1'b0;
    pixel_col  = '0;
    pixel_data = '0;
    line_start = 1'b0;
    next_line  = '0;
    disp_valid = 1'b0;
    disp_col   = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_ready", 32'(ready), 32'(0));
    check("rst_rgb_valid", 32'(rgb_valid), 32'(0));
    check("rst_draw_start", 32'(draw_start), 32'(0));
    check("rst_draw_line", 32'(draw_line), 32'(0));
    check("rst_rgb", 32'(rgb), 32'(0));
    mcyc     = 0;
    msel     = 0;
    p_v      = 1'b0;
    p_rgb    = '0;
    last_rgb = '0;
    m_line   = '0;
    for (int b = 0; b < 2; b++)
      for (int c = 0; c < W; c++) mbuf[b][c] = EMPTY;
  endtask

  task automatic write_px(input logic [9:0] col, input logic [15:0] data);
    wren = 1'b1; pixel_col = col; pixel_data = data;
    tick();
    wren = 1'b0;
  endtask

  task automatic swap(input logic [9:0] nl);
    line_start = 1'b1; next_line = nl;
    tick();
    line_start = 1'b0;
  endtask

  task automatic read_px(input logic [9:0] col);
    disp_valid = 1'b1; disp_col = col;
    tick();
    disp_valid = 1'b0;
  endtask

  task automatic read_all();
    disp_valid = 1'b1;
    for (int c = 0; c < W; c++) begin
      disp_col = 10'(c);
      tick();
    end
    disp_valid = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    bg_color = 24'h123456;
    do_reset();
    repeat (W) tick();
    check("ready_after_init", 32'(ready), 32'(1));

    // First line start, then a full scan of the empty buffer.
    swap(10'd7);
    read_all();

    // Opaque red, then clear-after-read.
    write_px(10'd5, 16'h7C00);
    swap(10'd8);
    read_px(10'd5);
    tick();
    check("red", 32'(rgb), 32'(24'hFF0000));
    read_px(10'd5);
    tick();
    check("cleared", 32'(rgb), 32'(24'h123456));

    // Transparent entry shows background; opaque blue expands to full scale.
    write_px(10'd10, 16'h801F);
    swap(10'd9);
    read_px(10'd10);
    tick();
    check("transparent", 32'(rgb), 32'(24'h123456));
    write_px(10'd10, 16'h001F);
    swap(10'd10);
    read_px(10'd10);
    tick();
    check("blue", 32'(rgb), 32'(24'h0000FF));

    // Out-of-range write is dropped; out-of-range read gives background.
    write_px(10'd700, 16'h7FFF);
    swap(10'd11);
    read_all();
    read_px(10'd700);
    tick();
    check("oor_valid", 32'(rgb_valid), 32'(1));
    check("oor_rgb", 32'(rgb), 32'(24'h123456));

    // A write in the swap cycle lands in the buffer becoming the display one.
    wren = 1'b1; pixel_col = 10'd3; pixel_data = 16'h03E0;
    swap(10'd12);
    wren = 1'b0;
    read_px(10'd3);
    tick();
    check("same_cycle_swap", 32'(rgb), 32'(24'h00FF00));

    // Random traffic, biased towards a few columns to exercise overwrites,
    // re-reads and swaps in flight.
    tick();
    tick();
    bg_color = 24'($urandom);
    for (int i = 0; i < 3000; i++) begin
      wren       = 1'($urandom_range(0, 1));
      pixel_col  = ($urandom_range(0, 15) == 0) ? 10'($urandom_range(640, 1023))
                 : ($urandom_range(0, 1) == 0) ? 10'($urandom_range(0, 15))
                 : 10'($urandom_range(0, W - 1));
      pixel_data = 16'($urandom);
      line_start = ($urandom_range(0, 29) == 0);
      next_line  = 10'($urandom);
      disp_valid = ($urandom_range(0, 3) != 0);
      disp_col   = ($urandom_range(0, 15) == 0) ? 10'($urandom_range(640, 1023))
                 : ($urandom_range(0, 1) == 0) ? 10'($urandom_range(0, 15))
                 : 10'($urandom_range(0, W - 1));
      tick();
    end
    idle_inputs();
    tick();
    tick();

    // Reset in the middle of a scan after drawing, then everything reads empty.
    bg_color = 24'h123456;
    for (int c = 0; c < 20; c++) write_px(10'(c), 16'h1234 + 16'(c));
    swap(10'd13);
    disp_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      disp_col = 10'(c);
      tick();
    end
    do_reset();
    repeat (W) tick();
    swap(10'd14);
    read_all();
    swap(10'd15);
    read_all();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
